lcd_frame_sequencer: RTL and testbench

//  Owns a 2x16 character frame buffer and sequences the lcd driver so that panel contents track the buffer.

---
 rtl/lcd_frame_sequencer_pkg.sv | 32 +++
 rtl/lcd_frame_sequencer_if.sv | 9 +
 rtl/lcd_frame_sequencer_buffer.sv | 38 +++
 rtl/lcd_frame_sequencer.sv | 131 +++++++++++++
 tb/tb_lcd_frame_sequencer.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/lcd_frame_sequencer_pkg.sv
// Shared types, constants and the DDRAM command builder for the LCD frame sequencer.
package lcd_pkg;

   typedef enum logic [2:0] {
      BOOT_HI,
      BOOT_LO,
      IDLE,
      ISSUE,
      WAIT_HI,
      WAIT_LO
   } lcd_seq_state_t;

   typedef enum logic [1:0] {
      JOB_LINE0,
      JOB_LINE1,
      JOB_CURSOR
   } lcd_job_t;

   localparam int unsigned COLS          = 16;
   localparam logic [7:0]  CMD_SET_DDRAM = 8'h80;
   localparam logic [6:0]  LINE0_ADDR    = 7'h00;
   localparam logic [6:0]  LINE1_ADDR    = 7'h40;
   localparam logic [7:0]  BLANK         = 8'h20;

   // {rs=0, set-DDRAM-address command} for a given line/column
   function automatic logic [8:0] ddram_cmd(input logic line, input logic [3:0] col);
      logic [6:0] addr;
      addr = (line ? LINE1_ADDR : LINE0_ADDR) + {3'b000, col};
      return {1'b0, CMD_SET_DDRAM | {1'b0, addr}};
   endfunction

endpackage

// File: rtl/lcd_frame_sequencer_if.sv
// Byte handshake between the frame sequencer (master) and the lcd driver (slave).
interface lcd_frame_sequencer_if;
   logic [8:0] lcd_d;
   logic       lcd_data_ready;
   logic       lcd_busy;

   modport master (output lcd_d, output lcd_data_ready, input lcd_busy);
   modport slave  (input lcd_d, input lcd_data_ready, output lcd_busy);
endinterface

// File: rtl/lcd_frame_sequencer_buffer.sv
// 2x16 character frame buffer: one write port, one combinational read port.
module lcd_frame_buffer
   import lcd_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       wr_en,
   input  logic [4:0] wr_addr,
   input  logic [7:0] wr_data,
   input  logic [4:0] rd_addr,
   output logic [7:0] rd_data
);

   logic [7:0] mem_q [32];
   logic [7:0] mem_d [32];

   // apply the single write port
   always_comb begin
      mem_d = mem_q;
      if (wr_en) begin
         mem_d[wr_addr] = wr_data;
      end
   end

   // storage, cleared to blanks on reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < 32; i++) begin
            mem_q[i] <= BLANK;
         end
      end else begin
         mem_q <= mem_d;
      end
   end

   assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/lcd_frame_sequencer.sv
// Frame sequencer: sends dirty lines (address command + 16 chars) and restores the cursor.
module lcd_frame_sequencer
   import lcd_pkg::*;
(
   input  logic                         clock,
   input  logic                         internal_reset,
   input  logic                         wr_en,
   input  logic [4:0]                   wr_addr,
   input  logic [7:0]                   wr_data,
   input  logic [4:0]                   cursor_pos,
   input  logic                         cursor_update,
   lcd_frame_sequencer_if.master        lcd,
   output logic                         idle
);

   localparam logic [3:0] LAST_COL = 4'(COLS - 1);

   lcd_seq_state_t state_q, state_d;
   lcd_job_t       job_q, job_d;
   logic [3:0]     col_q, col_d;
   logic           data_phase_q, data_phase_d;
   logic [1:0]     dirty_q, dirty_d;
   logic           cursor_pending_q, cursor_pending_d;
   logic [8:0]     lcd_d_q, lcd_d_d;
   logic [4:0]     rd_addr;
   logic [7:0]     rd_data;

   lcd_frame_buffer u_buf (
      .clk     (clock),
      .rst     (internal_reset),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

   // the character read is always the one about to be built: col 0 after the address, else col+1
   assign rd_addr = {job_q == JOB_LINE1, data_phase_q ? col_q + 4'd1 : 4'd0};

   // next-state, job selection and flag bookkeeping
   always_comb begin
      state_d          = state_q;
      job_d            = job_q;
      col_d            = col_q;
      data_phase_d     = data_phase_q;
      lcd_d_d          = lcd_d_q;
      dirty_d          = dirty_q;
      cursor_pending_d = cursor_pending_q | cursor_update;

      unique case (state_q)
         BOOT_HI: if (lcd.lcd_busy)  state_d = BOOT_LO;
         BOOT_LO: if (!lcd.lcd_busy) state_d = IDLE;
         IDLE: begin
            data_phase_d = 1'b0;
            if (dirty_q[0]) begin
               job_d   = JOB_LINE0;
               lcd_d_d = ddram_cmd(1'b0, 4'd0);
               state_d = ISSUE;
            end else if (dirty_q[1]) begin
               job_d   = JOB_LINE1;
               lcd_d_d = ddram_cmd(1'b1, 4'd0);
               state_d = ISSUE;
            end else if (cursor_pending_q) begin
               job_d            = JOB_CURSOR;
               lcd_d_d          = ddram_cmd(cursor_pos[4], cursor_pos[3:0]);
               cursor_pending_d = cursor_update;
               state_d          = ISSUE;
            end
         end
         ISSUE: begin
            if (job_q != JOB_CURSOR && !data_phase_q) begin
               dirty_d[job_q == JOB_LINE1] = 1'b0;
            end
            state_d = WAIT_HI;
         end
         WAIT_HI: if (lcd.lcd_busy) state_d = WAIT_LO;
         WAIT_LO: begin
            if (!lcd.lcd_busy) begin
               if (job_q == JOB_CURSOR) begin
                  state_d = IDLE;
               end else if (!data_phase_q) begin
                  data_phase_d = 1'b1;
                  col_d        = 4'd0;
                  lcd_d_d      = {1'b1, rd_data};
                  state_d      = ISSUE;
               end else if (col_q == LAST_COL) begin
                  cursor_pending_d = 1'b1;
                  state_d          = IDLE;
               end else begin
                  col_d   = col_q + 4'd1;
                  lcd_d_d = {1'b1, rd_data};
                  state_d = ISSUE;
               end
            end
         end
         default: state_d = BOOT_HI;
      endcase

      // applied last so a write beats the address-command clear in the same cycle
      if (wr_en) begin
         dirty_d[wr_addr[4]] = 1'b1;
      end
   end

   // state and flag registers
   always_ff @(posedge clock or posedge internal_reset) begin
      if (internal_reset) begin
         state_q          <= BOOT_HI;
         job_q            <= JOB_LINE0;
         col_q            <= '0;
         data_phase_q     <= 1'b0;
         dirty_q          <= '1;
         cursor_pending_q <= 1'b1;
         lcd_d_q          <= '0;
      end else begin
         state_q          <= state_d;
         job_q            <= job_d;
         col_q            <= col_d;
         data_phase_q     <= data_phase_d;
         dirty_q          <= dirty_d;
         cursor_pending_q <= cursor_pending_d;
         lcd_d_q          <= lcd_d_d;
      end
   end

   assign lcd.lcd_d          = lcd_d_q;
   assign lcd.lcd_data_ready = (state_q == ISSUE);
   assign idle               = (state_q == IDLE) && (dirty_q == 2'b00) && !cursor_pending_q;

endmodule

// File: tb/tb_lcd_frame_sequencer.sv
// Directed bench for lcd_frame_sequencer with a behavioural driver-side handshake.
module tb_lcd_frame_sequencer;
   import lcd_pkg::*;

   logic       clock = 1'b0;
   logic       internal_reset = 1'b1;
   logic       wr_en = 1'b0;
   logic [4:0] wr_addr = '0;
   logic [7:0] wr_data = '0;
   logic [4:0] cursor_pos = '0;
   logic       cursor_update = 1'b0;
   logic       idle;

   int unsigned total = 0;
   int unsigned bad = 0;
   logic [7:0] model [32];

   lcd_frame_sequencer_if lcd_if ();

   lcd_frame_sequencer dut (
      .clock          (clock),
      .internal_reset (internal_reset),
      .wr_en          (wr_en),
      .wr_addr        (wr_addr),
      .wr_data        (wr_data),
      .cursor_pos     (cursor_pos),
      .cursor_update  (cursor_update),
      .lcd            (lcd_if),
      .idle           (idle)
   );

   always #5 clock = ~clock;

   initial begin
      #400000;
      $display("FAIL watchdog got=running want=finished");
      $fatal(1);
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", tag, got, want);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) model[i] = 8'h20;
   endtask

   task automatic put_char(input logic [4:0] a, input logic [7:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      model[a] = d;
      @(negedge clock);
      wr_en = 1'b0;
   endtask

   // serve one byte: wait for the request, accept after a delay, optional write hook
   task automatic serve_one(input bit do_wr, input bit at_issue, input logic [4:0] a,
                            input logic [7:0] d, output logic [8:0] b, output bit ok);
      int unsigned n = 0;
      ok = 1'b0;
      b  = '0;
      while (!lcd_if.lcd_data_ready && n < 200) begin
         @(negedge clock);
         n++;
      end
      if (lcd_if.lcd_data_ready) begin
         ok = 1'b1;
         if (do_wr && at_issue) put_char(a, d); else @(negedge clock);
         @(negedge clock);
         b = lcd_if.lcd_d;
         lcd_if.lcd_busy = 1'b1;
         if (do_wr && !at_issue) put_char(a, d); else @(negedge clock);
         repeat (2) @(negedge clock);
         lcd_if.lcd_busy = 1'b0;
         @(negedge clock);
      end
   endtask

   task automatic expect_byte(input string tag, input logic [8:0] want, input bit do_wr,
                              input bit at_issue, input logic [4:0] a, input logic [7:0] d);
      logic [8:0] b;
      bit ok;
      serve_one(do_wr, at_issue, a, d, b, ok);
      check_val({tag, "_req"}, {31'd0, ok}, 32'd1);
      check_val(tag, {23'd0, b}, {23'd0, want});
   endtask

   task automatic expect_line(input string tag, input int n, input int wr_idx,
                              input bit at_issue, input logic [4:0] a, input logic [7:0] d);
      logic [8:0] want;
      for (int i = 0; i < 17; i++) begin
         want = (i == 0) ? ((n != 0) ? 9'h0C0 : 9'h080) : {1'b1, model[n*16 + i - 1]};
         expect_byte($sformatf("%s_l%0d_b%0d", tag, n, i), want, (i == wr_idx), at_issue, a, d);
      end
   endtask

   task automatic expect_quiet(input string tag);
      int unsigned pulses = 0;
      repeat (40) begin
         @(negedge clock);
         if (lcd_if.lcd_data_ready) pulses++;
      end
      check_val({tag, "_pulses"}, pulses, 32'd0);
      check_val({tag, "_idle"}, {31'd0, idle}, 32'd1);
   endtask

   task automatic boot(input string tag);
      repeat (3) @(negedge clock);
      check_val({tag, "_boot_idle"}, {31'd0, idle}, 32'd0);
      lcd_if.lcd_busy = 1'b1;
      repeat (4) @(negedge clock);
      check_val({tag, "_boot_rdy"}, {31'd0, lcd_if.lcd_data_ready}, 32'd0);
      lcd_if.lcd_busy = 1'b0;
   endtask

   task automatic expect_full(input string tag);
      expect_line(tag, 0, -1, 1'b0, 5'd0, 8'd0);
      expect_line(tag, 1, -1, 1'b0, 5'd0, 8'd0);
      expect_byte({tag, "_cur"}, 9'h080, 1'b0, 1'b0, 5'd0, 8'd0);
      expect_quiet(tag);
   endtask

   initial begin
      logic rdy_seen;
      lcd_if.lcd_busy = 1'b0;
      model_reset();

      // reset values
      #1;
      check_val("rst_d",   {23'd0, lcd_if.lcd_d}, 32'h000);
      check_val("rst_rdy", {31'd0, lcd_if.lcd_data_ready}, 32'd0);
      check_val("rst_idle", {31'd0, idle}, 32'd0);
      repeat (2) @(negedge clock);
      internal_reset = 1'b0;

      // test 1: boot then full refresh
      boot("t1");
      expect_full("t1");

      // test 2: single write in idle, two-cycle latency, only line 0
      put_char(5'h03, 8'h37);
      check_val("t2_lat1", {31'd0, lcd_if.lcd_data_ready}, 32'd0);
      @(negedge clock);
      check_val("t2_lat2", {31'd0, lcd_if.lcd_data_ready}, 32'd1);
      expect_line("t2", 0, -1, 1'b0, 5'd0, 8'd0);
      expect_byte("t2_cur", 9'h080, 1'b0, 1'b0, 5'd0, 8'd0);
      expect_quiet("t2");

      // test 3: write to line 1 col 2 while col 5 is in flight
      put_char(5'h15, 8'h41);
      expect_line("t3a", 1, 6, 1'b0, 5'h12, 8'h2B);
      expect_line("t3b", 1, -1, 1'b0, 5'd0, 8'd0);
      check_val("t3_model", {24'd0, model[5'h12]}, 32'h2B);
      expect_byte("t3_cur", 9'h080, 1'b0, 1'b0, 5'd0, 8'd0);
      expect_quiet("t3");

      // test 4: write collides with line 0 address command
      put_char(5'h01, 8'h31);
      expect_line("t4a", 0, 0, 1'b1, 5'h00, 8'h30);
      expect_line("t4b", 0, -1, 1'b0, 5'd0, 8'd0);
      expect_byte("t4_cur", 9'h080, 1'b0, 1'b0, 5'd0, 8'd0);
      expect_quiet("t4");

      // test 5: cursor-only update
      cursor_pos = 5'h1A;
      cursor_update = 1'b1;
      @(negedge clock);
      cursor_update = 1'b0;
      expect_byte("t5_cur", 9'h0CA, 1'b0, 1'b0, 5'd0, 8'd0);
      expect_quiet("t5");
      cursor_pos = 5'h00;

      // test 6: reset during line 0 character 8
      put_char(5'h08, 8'h38);
      expect_byte("t6_addr", 9'h080, 1'b0, 1'b0, 5'd0, 8'd0);
      for (int c = 0; c < 8; c++) begin
         expect_byte($sformatf("t6_c%0d", c), {1'b1, model[c]}, 1'b0, 1'b0, 5'd0, 8'd0);
      end
      rdy_seen = 1'b0;
      for (int k = 0; k < 200 && !rdy_seen; k++) begin
         if (lcd_if.lcd_data_ready) rdy_seen = 1'b1; else @(negedge clock);
      end
      check_val("t6_reach", {31'd0, rdy_seen}, 32'd1);
      check_val("t6_c8", {23'd0, lcd_if.lcd_d}, 32'h138);
      internal_reset = 1'b1;
      #1;
      check_val("t6_rst_d",   {23'd0, lcd_if.lcd_d}, 32'h000);
      check_val("t6_rst_rdy", {31'd0, lcd_if.lcd_data_ready}, 32'd0);
      check_val("t6_rst_idle", {31'd0, idle}, 32'd0);
      model_reset();
      repeat (3) @(negedge clock);
      internal_reset = 1'b0;
      boot("t6");
      expect_full("t6");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
